// File: rtl/wb_nic_reg_if.sv
// Wishbone master-side bus bundle between the core and the NIC.
//   cyc, stb   : master cycle / strobe
//   addr_sel   : slave index (top address bits of the master)
//   ack, err   : one-cycle transfer acknowledge / bus error
//   rdata      : registered read data returned to the master
// Modports: master (core side), slave (NIC side).
interface wb_nic_reg_if #(
  parameter int ADDR_SEL_WIDTH = 4,
  parameter int DATA_WIDTH     = 32
);
  logic                      cyc;
  logic                      stb;
  logic [ADDR_SEL_WIDTH-1:0] addr_sel;
  logic                      ack;
  logic                      err;
  logic [DATA_WIDTH-1:0]     rdata;

  modport master (
    output cyc, stb, addr_sel,
    input  ack, err, rdata
  );

  modport slave (
    input  cyc, stb, addr_sel,
    output ack, err, rdata
  );
endinterface

// File: rtl/wb_nic_reg.sv
// Registered Wishbone NIC: decodes the slave index of a single master,
// drives a one-hot slave select, waits for that slave's ack and returns a
// registered ack/read-data pair. Unmapped slaves and slaves that never
// answer are terminated with a one-cycle bus error, and the last errored
// slave plus a saturating error count are recorded.
//
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   wb             : master bus (cyc, stb, addr_sel in; ack, err, rdata out)
//   o_busy         : FSM not in IDLE (decoded from the state register)
//   o_slave_sel    : one-hot slave select, asserted only while ACTIVE
//   i_rdata        : packed per-slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_ack          : per-slave acknowledge
//   o_err_slave    : index of the most recently errored slave
//   o_err_count    : saturating error counter
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for cyc & stb; only state that accepts a request
// ACTIVE | slave selected, waiting for its ack or the timeout
// RESP   | o_wb_ack high for this cycle with the captured read data
// ERR    | o_wb_err high for this cycle with ERR_RDATA
module wb_nic_reg #(
  parameter int ADDR_SEL_WIDTH = 4,
  parameter int DATA_WIDTH     = 32,
  localparam int N             = 2 ** ADDR_SEL_WIDTH,
  parameter logic [N-1:0] SLAVE_MASK = 16'h0003,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  wb_nic_reg_if.slave               wb,
  output logic                      o_busy,
  output logic [N-1:0]              o_slave_sel,
  input  logic [N*DATA_WIDTH-1:0]   i_rdata,
  input  logic [N-1:0]              i_ack,
  output logic [ADDR_SEL_WIDTH-1:0] o_err_slave,
  output logic [7:0]                o_err_count
);

  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t                    state, state_next;
  logic [ADDR_SEL_WIDTH-1:0] idx, idx_next;
  logic [TW-1:0]             to_cnt;
  logic                      slave_ack;
  logic [DATA_WIDTH-1:0]     slave_rdata;
  logic                      timeout_hit;

  // Only the selected slave's ack and data are looked at.
  assign slave_ack   = i_ack[idx];
  assign slave_rdata = i_rdata[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  assign o_busy = (state != IDLE);

  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (wb.cyc && wb.stb) begin
          idx_next   = wb.addr_sel;
          state_next = SLAVE_MASK[wb.addr_sel] ? ACTIVE : ERR;
        end
      end
      ACTIVE: begin
        // A master that drops cyc has abandoned the transfer, so the
        // abort outranks a late ack. Ack outranks the timeout.
        if (!wb.cyc) begin
          state_next = IDLE;
        end else if (slave_ack) begin
          state_next = RESP;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      RESP:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Counter sits at zero outside ACTIVE, so it is already clear on entry.
  always_ff @(posedge i_clk) begin
    if (i_reset || state != ACTIVE) begin
      to_cnt <= '0;
    end else if (!slave_ack) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state they belong to (ack in RESP, err in ERR, select in ACTIVE).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wb.ack      <= 1'b0;
      wb.err      <= 1'b0;
      wb.rdata    <= '0;
      o_slave_sel <= '0;
      o_err_slave <= '0;
      o_err_count <= '0;
    end else begin
      wb.ack      <= (state_next == RESP);
      wb.err      <= (state_next == ERR);
      o_slave_sel <= (state_next == ACTIVE) ? (N'(1) << idx_next) : '0;
      if (state == ACTIVE && state_next == RESP) begin
        wb.rdata <= slave_rdata;
      end
      if (state_next == ERR) begin
        wb.rdata    <= ERR_RDATA;
        o_err_slave <= idx_next;
        if (o_err_count != 8'hFF) begin
          o_err_count <= o_err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_nic_reg.sv
module tb_wb_nic_reg;
  localparam int A = 4;
  localparam int D = 32;
  localparam int N = 16;
  localparam int T = 4;
  localparam logic [N-1:0]  MASK = 16'h0003;
  localparam logic [D-1:0]  ERRV = 32'hDEAD_BEEF;

  logic           clk;
  logic           reset;
  logic [N*D-1:0] i_rdata;
  logic [N-1:0]   i_ack;
  logic           o_busy;
  logic [N-1:0]   o_slave_sel;
  logic [A-1:0]   o_err_slave;
  logic [7:0]     o_err_count;

  wb_nic_reg_if #(.ADDR_SEL_WIDTH(A), .DATA_WIDTH(D)) bus ();

  wb_nic_reg #(
    .ADDR_SEL_WIDTH(A), .DATA_WIDTH(D), .SLAVE_MASK(MASK),
    .TIMEOUT_CYCLES(T), .ERR_RDATA(ERRV)
  ) dut (
    .i_clk(clk), .i_reset(reset), .wb(bus), .o_busy(o_busy),
    .o_slave_sel(o_slave_sel), .i_rdata(i_rdata), .i_ack(i_ack),
    .o_err_slave(o_err_slave), .o_err_count(o_err_count)
  );

  int checks = 0;
  int failures = 0;

  // reference state: what the NIC has reported so far
  logic [D-1:0] m_rdata;
  logic [A-1:0] m_err_slave;
  int           m_err_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One master transaction, driven and checked cycle by cycle. Called just
  // after a negedge; returns just after the negedge of the idle cycle that
  // follows the response (or the abort).
  //   ack_at   : ACTIVE cycle in which the slave acks (>T means never)
  //   other_at : cycle in which a non-selected slave pulses its ack
  //   drop_at  : cycle in which the master drops cyc (0 = never)
  task automatic run_txn(input int idx, input int ack_at, input int other,
                         input int other_at, input int drop_at,
                         input logic [D-1:0] data);
    bit mapped;
    int act_end, resp_c, last;
    bit is_err;
    logic [N-1:0] e_sel;
    logic [N+2:0] got, exp;
    mapped = MASK[idx];
    resp_c = 0;
    is_err = 1'b0;
    if (drop_at > 0) begin
      act_end = drop_at;
      last    = drop_at + 1;
    end else if (!mapped) begin
      act_end = 0; resp_c = 1; is_err = 1'b1;
    end else if (ack_at >= 1 && ack_at <= T) begin
      act_end = ack_at; resp_c = ack_at + 1;
    end else begin
      act_end = T; resp_c = T + 1; is_err = 1'b1;
    end
    if (drop_at == 0) last = resp_c + 1;

    for (int s = 0; s < N; s++) i_rdata[s*D +: D] = $urandom();
    i_rdata[idx*D +: D] = data;
    i_ack        = '0;
    bus.cyc      = 1'b1;
    bus.stb      = 1'b1;
    bus.addr_sel = A'(idx);
    @(posedge clk);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c == resp_c) begin
        if (is_err) begin
          m_rdata     = ERRV;
          m_err_slave = A'(idx);
          if (m_err_count < 255) m_err_count++;
        end else begin
          m_rdata = data;
        end
      end
      e_sel = '0;
      if (c <= act_end) e_sel[idx] = 1'b1;
      exp = {(c <= act_end) || (c == resp_c), e_sel,
             (c == resp_c) && !is_err, (c == resp_c) && is_err};
      got = {o_busy, o_slave_sel, bus.ack, bus.err};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL txn_ctrl slave=%0d cycle=%0d busy/sel/ack/err got %b want %b",
                 idx, c, got, exp);
      end
      checks++;
      if (bus.rdata !== m_rdata) begin
        failures++;
        $display("FAIL txn_rdata slave=%0d cycle=%0d got %h want %h", idx, c, bus.rdata, m_rdata);
      end
      checks++;
      if (o_err_slave !== m_err_slave || o_err_count !== 8'(m_err_count)) begin
        failures++;
        $display("FAIL txn_errstat slave=%0d cycle=%0d got slave=%0d count=%0d want slave=%0d count=%0d",
                 idx, c, o_err_slave, o_err_count, m_err_slave, m_err_count);
      end
      i_ack = '0;
      if (c == ack_at) i_ack[idx] = 1'b1;
      if (c == other_at) i_ack[other] = 1'b1;
      if (c == resp_c || c == drop_at) begin
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
      end
    end
    i_ack   = '0;
    bus.cyc = 1'b0;
    bus.stb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.addr_sel = '0;
    i_ack = '0; i_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ack, bus.err, o_busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got ack/err/busy=%b want 000", {bus.ack, bus.err, o_busy});
    end
    checks++;
    if (o_slave_sel !== '0 || bus.rdata !== '0) begin
      failures++;
      $display("FAIL reset_data got sel=%h rdata=%h want 0", o_slave_sel, bus.rdata);
    end
    checks++;
    if (o_err_slave !== '0 || o_err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_errstat got slave=%0d count=%0d want 0", o_err_slave, o_err_count);
    end
    reset = 1'b0;
    m_rdata = '0; m_err_slave = '0; m_err_count = 0;
    @(negedge clk);
  endtask

  task automatic test_read_ack();
    run_txn(1, 3, 0, 0, 0, 32'h1234_5678);
  endtask

  task automatic test_unmapped();
    run_txn(5, 1, 1, 1, 0, 32'h0BAD_0BAD);
  endtask

  task automatic test_timeout();
    run_txn(1, 99, 0, 0, 0, 32'hCAFE_0001);
  endtask

  task automatic test_ack_priority();
    run_txn(1, T, 0, 2, 0, 32'hA5A5_0F0F);
  endtask

  task automatic test_abort();
    run_txn(1, 99, 0, 0, 2, 32'h5555_AAAA);
  endtask

  task automatic test_back_to_back();
    run_txn(0, 1, 1, 1, 0, 32'h0000_0001);
    run_txn(1, 1, 0, 0, 0, 32'h0000_0002);
    run_txn(9, 1, 0, 0, 0, 32'h0000_0003);
    run_txn(0, 2, 0, 0, 0, 32'h0000_0004);
  endtask

  task automatic test_random(input int n);
    int idx, ack_at, other, other_at, drop_at;
    for (int i = 0; i < n; i++) begin
      idx = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 1) : $urandom_range(2, 15);
      ack_at   = $urandom_range(1, 6);
      other    = (idx + $urandom_range(1, 15)) % N;
      other_at = $urandom_range(1, 6);
      drop_at  = 0;
      if (MASK[idx] && $urandom_range(0, 7) == 0) begin
        drop_at = $urandom_range(1, T - 1);
        ack_at  = 99;
      end
      run_txn(idx, ack_at, other, other_at, drop_at, $urandom());
    end
  endtask

  task automatic test_reset_mid_active();
    logic [N+D+A+10:0] all_out;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.addr_sel = 4'd1; i_ack = '0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_slave_sel !== 16'h0002 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_active got sel=%h busy=%b want 0002 1", o_slave_sel, o_busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    all_out = {bus.ack, bus.err, o_busy, o_slave_sel, bus.rdata, o_err_slave, o_err_count};
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got %h want 0", all_out);
    end
    reset = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    m_rdata = '0; m_err_slave = '0; m_err_count = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || bus.ack !== 1'b0 || bus.err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after got busy/ack/err=%b want 000", {o_busy, bus.ack, bus.err});
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      run_txn($urandom_range(2, 15), 1, 0, 0, 0, $urandom());
    end
    checks++;
    if (o_err_count !== 8'd255) begin
      failures++;
      $display("FAIL saturation got %0d want 255", o_err_count);
    end
  endtask

  initial begin
    test_reset();
    test_read_ack();
    test_unmapped();
    test_timeout();
    test_ack_priority();
    test_abort();
    test_back_to_back();
    test_random(60);
    test_reset_mid_active();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
